regfile_sb: RTL and testbench

- Architectural register file with an integrated scoreboard. It sits between decode and writeback.
- It accepts the single committed write produced by the writeback stage (reg_write / rd / result). It serves two combinational read ports to decode, with write-through bypass.
- It tracks in-flight destination registers (ALU and multi-cycle MUL) and raises a decode stall on RAW or WAW hazards.
- It is the consuming end of the writeback interface.

---
 rtl/brisc_pkg.sv | 13 +
 rtl/regfile_sb_scoreboard.sv | 57 +++++
 rtl/regfile_sb.sv | 64 ++++++
 tb/tb_regfile_sb.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/brisc_pkg.sv
// Shared core constants and types for the brisc pipeline.
package brisc_pkg;

   localparam int XLEN     = 32;
   localparam int REG_BITS = 5;
   localparam int NUM_REGS = 2 ** REG_BITS;

   localparam logic [REG_BITS-1:0] ZERO_REG = '0;

   typedef logic [REG_BITS-1:0] reg_idx_t;
   typedef logic [XLEN-1:0]     xword_t;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard: tracks one outstanding producer per register and
// raises the decode stall on RAW/WAW hazards. Writeback in the same cycle
// resolves a hazard; a new issue to a register being written back wins.
module regfile_sb_scoreboard
   import brisc_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                flush_in,
   input  logic                wr_en_in,
   input  logic [REG_BITS-1:0] wr_rd_in,
   input  logic [REG_BITS-1:0] rs1_in,
   input  logic [REG_BITS-1:0] rs2_in,
   input  logic                rs1_used_in,
   input  logic                rs2_used_in,
   input  logic                issue_valid_in,
   input  logic [REG_BITS-1:0] issue_rd_in,
   output logic                stall_out,
   output logic [NUM_REGS-1:0] busy_mask_out
);

   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic [NUM_REGS-1:0] wb_onehot;
   logic [NUM_REGS-1:0] eff_busy;
   logic                hazard;
   logic                issue_accept;

   // Hazard view for this cycle: a register being written back now is free.
   always_comb begin
      wb_onehot = '0;
      if (wr_en_in && wr_rd_in != ZERO_REG) wb_onehot[wr_rd_in] = 1'b1;
      eff_busy = busy_q & ~wb_onehot;
      hazard   = (rs1_used_in & eff_busy[rs1_in])
               | (rs2_used_in & eff_busy[rs2_in])
               | eff_busy[issue_rd_in];
      stall_out    = issue_valid_in & hazard;
      issue_accept = issue_valid_in & ~hazard & (issue_rd_in != ZERO_REG) & ~flush_in;
   end

   // Next busy vector: clear on writeback, then set on accepted issue (set
   // wins), flush drops everything; x0 is never tracked.
   always_comb begin
      busy_d = busy_q & ~wb_onehot;
      if (issue_accept) busy_d[issue_rd_in] = 1'b1;
      if (flush_in)     busy_d = '0;
      busy_d[0] = 1'b0;
   end

   // Busy state register; reset takes priority over everything.
   always_ff @(posedge clk) begin
      if (reset) busy_q <= '0;
      else       busy_q <= busy_d;
   end

   assign busy_mask_out = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Architectural register file with write-through bypass reads and an
// integrated in-flight destination scoreboard.
module regfile_sb
   import brisc_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                flush_in,
   input  logic                wr_en_in,
   input  logic [REG_BITS-1:0] wr_rd_in,
   input  logic [XLEN-1:0]     wr_data_in,
   input  logic [REG_BITS-1:0] rs1_in,
   input  logic [REG_BITS-1:0] rs2_in,
   input  logic                rs1_used_in,
   input  logic                rs2_used_in,
   output logic [XLEN-1:0]     rd1_out,
   output logic [XLEN-1:0]     rd2_out,
   input  logic                issue_valid_in,
   input  logic [REG_BITS-1:0] issue_rd_in,
   output logic                stall_out,
   output logic [NUM_REGS-1:0] busy_mask_out
);

   xword_t regs_q [NUM_REGS];
   logic   wr_live;

   assign wr_live = wr_en_in && (wr_rd_in != ZERO_REG);

   // Register array; x0 is never written so it stays zero after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (wr_live) begin
         regs_q[wr_rd_in] <= wr_data_in;
      end
   end

   // Read ports: x0 forced to zero, same-cycle writeback forwarded.
   always_comb begin
      rd1_out = regs_q[rs1_in];
      if (wr_live && wr_rd_in == rs1_in) rd1_out = wr_data_in;
      if (rs1_in == ZERO_REG)            rd1_out = '0;
      rd2_out = regs_q[rs2_in];
      if (wr_live && wr_rd_in == rs2_in) rd2_out = wr_data_in;
      if (rs2_in == ZERO_REG)            rd2_out = '0;
   end

   regfile_sb_scoreboard u_sb (
      .clk            (clk),
      .reset          (reset),
      .flush_in       (flush_in),
      .wr_en_in       (wr_en_in),
      .wr_rd_in       (wr_rd_in),
      .rs1_in         (rs1_in),
      .rs2_in         (rs2_in),
      .rs1_used_in    (rs1_used_in),
      .rs2_used_in    (rs2_used_in),
      .issue_valid_in (issue_valid_in),
      .issue_rd_in    (issue_rd_in),
      .stall_out      (stall_out),
      .busy_mask_out  (busy_mask_out)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed-vector bench for regfile_sb with hand-computed expectations.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush_in;
   logic        wr_en_in;
   logic [4:0]  wr_rd_in;
   logic [31:0] wr_data_in;
   logic [4:0]  rs1_in, rs2_in;
   logic        rs1_used_in, rs2_used_in;
   logic [31:0] rd1_out, rd2_out;
   logic        issue_valid_in;
   logic [4:0]  issue_rd_in;
   logic        stall_out;
   logic [31:0] busy_mask_out;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   regfile_sb dut (
      .clk            (clk),
      .reset          (reset),
      .flush_in       (flush_in),
      .wr_en_in       (wr_en_in),
      .wr_rd_in       (wr_rd_in),
      .wr_data_in     (wr_data_in),
      .rs1_in         (rs1_in),
      .rs2_in         (rs2_in),
      .rs1_used_in    (rs1_used_in),
      .rs2_used_in    (rs2_used_in),
      .rd1_out        (rd1_out),
      .rd2_out        (rd2_out),
      .issue_valid_in (issue_valid_in),
      .issue_rd_in    (issue_rd_in),
      .stall_out      (stall_out),
      .busy_mask_out  (busy_mask_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then settle inputs away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] rd, input logic [31:0] d);
      wr_en_in = 1'b1; wr_rd_in = rd; wr_data_in = d;
   endtask

   task automatic issue(input logic [4:0] rd);
      issue_valid_in = 1'b1; issue_rd_in = rd;
   endtask

   task automatic idle();
      wr_en_in = 1'b0; issue_valid_in = 1'b0; flush_in = 1'b0;
      rs1_used_in = 1'b0; rs2_used_in = 1'b0;
   endtask

   initial begin
      reset = 1'b1; idle();
      wr_rd_in = '0; wr_data_in = '0; issue_rd_in = '0;
      rs1_in = 5'd5; rs2_in = 5'd7;
      tick(); tick();
      reset = 1'b0; #1;
      chk("rst_busy",  busy_mask_out, 32'h0);
      chk("rst_stall", {31'b0, stall_out}, 32'h0);
      chk("rst_rd1",   rd1_out, 32'h0);
      chk("rst_rd2",   rd2_out, 32'h0);

      // basic write / read, x0 behaviour
      wr(5'd5, 32'hDEADBEEF); tick(); idle();
      rs1_in = 5'd5; #1;
      chk("rd_x5", rd1_out, 32'hDEADBEEF);
      rs1_in = 5'd0; wr(5'd0, 32'h1234); #1;
      chk("x0_bypass", rd1_out, 32'h0);
      tick(); idle(); #1;
      chk("x0_after_wr", rd1_out, 32'h0);

      // same-cycle bypass on port 2
      rs2_in = 5'd7; wr(5'd7, 32'hA5A5A5A5); #1;
      chk("bypass_rd2", rd2_out, 32'hA5A5A5A5);
      tick(); idle(); #1;
      chk("x7_stored", rd2_out, 32'hA5A5A5A5);

      // RAW on rs1
      issue(5'd3); #1;
      chk("iss3_nostall", {31'b0, stall_out}, 32'h0);
      tick(); idle(); #1;
      chk("busy3", busy_mask_out, 32'h0000_0008);
      rs1_in = 5'd3; rs1_used_in = 1'b1; issue(5'd8); #1;
      chk("raw_stall", {31'b0, stall_out}, 32'h1);
      tick(); #1;
      chk("raw_hold", {31'b0, stall_out}, 32'h1);
      chk("raw_hold_busy", busy_mask_out, 32'h0000_0008);
      issue_valid_in = 1'b0; #1;
      chk("stall_gated", {31'b0, stall_out}, 32'h0);
      issue(5'd8); wr(5'd3, 32'h33); #1;
      chk("raw_wb_stall", {31'b0, stall_out}, 32'h0);
      chk("raw_wb_rd1", rd1_out, 32'h33);
      tick(); idle(); #1;
      chk("busy8", busy_mask_out, 32'h0000_0100);
      wr(5'd8, 32'h88); tick(); idle(); #1;
      chk("busy_clr8", busy_mask_out, 32'h0);

      // RAW on rs2, rs2_used gating
      issue(5'd11); tick(); idle();
      rs2_in = 5'd11; rs2_used_in = 1'b1; issue(5'd12); #1;
      chk("raw2_stall", {31'b0, stall_out}, 32'h1);
      rs2_used_in = 1'b0; #1;
      chk("rs2_unused", {31'b0, stall_out}, 32'h0);
      tick(); idle(); #1;
      chk("busy11_12", busy_mask_out, 32'h0000_1800);
      wr(5'd11, 32'h0); tick(); wr(5'd12, 32'h0); tick(); idle(); #1;
      chk("busy_clr11_12", busy_mask_out, 32'h0);

      // WAW, then same-cycle writeback + reissue (set wins)
      issue(5'd4); tick(); idle();
      issue(5'd4); #1;
      chk("waw_stall", {31'b0, stall_out}, 32'h1);
      wr(5'd4, 32'h44); #1;
      chk("waw_wb_stall", {31'b0, stall_out}, 32'h0);
      tick(); idle(); #1;
      chk("waw_setwins", busy_mask_out, 32'h0000_0010);
      issue(5'd0); #1;
      chk("x0_nostall", {31'b0, stall_out}, 32'h0);
      tick(); idle(); #1;
      chk("x0_notbusy", busy_mask_out, 32'h0000_0010);
      wr(5'd4, 32'h45); tick(); idle();

      // flush with concurrent issue and write
      issue(5'd2); tick(); issue(5'd9); tick(); idle(); #1;
      chk("busy2_9", busy_mask_out, 32'h0000_0204);
      flush_in = 1'b1; issue(5'd10); wr(5'd2, 32'h22); tick(); idle(); #1;
      chk("flush_busy", busy_mask_out, 32'h0);
      rs1_in = 5'd2; #1;
      chk("flush_wr", rd1_out, 32'h22);
      wr(5'd9, 32'h55); tick(); idle();
      rs1_in = 5'd9; #1;
      chk("post_flush_wr", rd1_out, 32'h55);
      chk("post_flush_busy", busy_mask_out, 32'h0);

      // reset mid-operation
      wr(5'd6, 32'h77); tick(); idle();
      issue(5'd6); tick(); idle();
      rs1_in = 5'd6; #1;
      chk("busy6", busy_mask_out, 32'h0000_0040);
      chk("x6_val", rd1_out, 32'h77);
      reset = 1'b1; tick(); reset = 1'b0;
      rs1_used_in = 1'b1; issue(5'd6); #1;
      chk("rst2_busy", busy_mask_out, 32'h0);
      chk("rst2_x6", rd1_out, 32'h0);
      chk("rst2_stall", {31'b0, stall_out}, 32'h0);
      idle(); rs1_in = 5'd5; #1;
      chk("rst2_x5", rd1_out, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
